// File: rtl/cordic_result_collector.sv
// Result collector for the pipelined CORDIC core: follows issued ops down a fixed-latency tag
// line and buffers results in a credit-protected FIFO. Option macro: CORDIC_COLLECT_BYPASS_EN.
module cordic_result_collector #(
  parameter int unsigned LATENCY = 28,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [1:0]          issue_mode,
  input  logic [TAG_W-1:0]    issue_tag,
  input  logic signed [31:0]  pipe_x,
  input  logic signed [31:0]  pipe_y,
  input  logic signed [31:0]  pipe_angle,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [31:0]  out_x,
  output logic signed [31:0]  out_y,
  output logic signed [31:0]  out_angle,
  output logic [1:0]          out_mode,
  output logic [TAG_W-1:0]    out_tag,
  output logic [6:0]          inflight
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 3 * 32 + 2 + TAG_W;
  localparam logic [7:0] DepthW = 8'(DEPTH);

  logic               accept;
  logic               emerge;
  logic               bypass;
  logic               fifo_wr;
  logic               fifo_pop;
  logic               fifo_empty;
  logic [AW:0]        fifo_count;
  logic [7:0]         credit_sum;
  logic [EW-1:0]      wr_entry;
  logic [EW-1:0]      head;

  logic [LATENCY-1:0] dl_vld_q, dl_vld_d;
  logic [1:0]         dl_mode_q [LATENCY];
  logic [1:0]         dl_mode_d [LATENCY];
  logic [TAG_W-1:0]   dl_tag_q  [LATENCY];
  logic [TAG_W-1:0]   dl_tag_d  [LATENCY];
  logic [6:0]         inflight_q, inflight_d;
  logic [AW:0]        wptr_q, wptr_d;
  logic [AW:0]        rptr_q, rptr_d;
  logic [EW-1:0]      mem_q [DEPTH];
  logic [EW-1:0]      mem_d [DEPTH];

  assign fifo_count = wptr_q - rptr_q;
  assign fifo_empty = (fifo_count == '0);

  // Credits are derived only from registered state; accepting while the sum is below DEPTH
  // keeps fifo_count + inflight <= DEPTH, so an emergence always finds a free slot.
  assign credit_sum  = 8'(fifo_count) + {1'b0, inflight_q};
  assign issue_ready = (credit_sum < DepthW);
  assign accept      = issue_valid & issue_ready;
  assign emerge      = dl_vld_q[LATENCY-1];
  assign inflight    = inflight_q;

  assign wr_entry = {pipe_x, pipe_y, pipe_angle, dl_mode_q[LATENCY-1], dl_tag_q[LATENCY-1]};
  assign head     = mem_q[rptr_q[AW-1:0]];

`ifdef CORDIC_COLLECT_BYPASS_EN
  assign bypass = fifo_empty & emerge & out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_wr  = emerge & ~bypass;
  assign fifo_pop = ~fifo_empty & out_ready;

  always_comb begin
    out_valid = ~fifo_empty;
    {out_x, out_y, out_angle, out_mode, out_tag} = head;
`ifdef CORDIC_COLLECT_BYPASS_EN
    if (bypass) begin
      out_valid = 1'b1;
      {out_x, out_y, out_angle, out_mode, out_tag} = wr_entry;
    end
`endif
  end

  always_comb begin
    dl_vld_d     = dl_vld_q;
    dl_mode_d    = dl_mode_q;
    dl_tag_d     = dl_tag_q;
    dl_vld_d[0]  = accept;
    dl_mode_d[0] = issue_mode;
    dl_tag_d[0]  = issue_tag;
    for (int unsigned k = 1; k < LATENCY; k++) begin
      dl_vld_d[k]  = dl_vld_q[k-1];
      dl_mode_d[k] = dl_mode_q[k-1];
      dl_tag_d[k]  = dl_tag_q[k-1];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !emerge) begin
      inflight_d = inflight_q + 7'd1;
    end else if (!accept && emerge) begin
      inflight_d = inflight_q - 7'd1;
    end
  end

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, fifo_wr};
    rptr_d = rptr_q + {{AW{1'b0}}, fifo_pop};
    mem_d  = mem_q;
    if (fifo_wr) begin
      mem_d[wptr_q[AW-1:0]] = wr_entry;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dl_vld_q   <= '0;
      dl_mode_q  <= '{default: '0};
      dl_tag_q   <= '{default: '0};
      inflight_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_q      <= '{default: '0};
    end else begin
      dl_vld_q   <= dl_vld_d;
      dl_mode_q  <= dl_mode_d;
      dl_tag_q   <= dl_tag_d;
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_cordic_result_collector.sv
// Self-checking bench for cordic_result_collector: a core model feeds pipe_*, a scoreboard
// queue holds expected results in issue order and a negedge monitor compares every pop.
module tb_cordic_result_collector;

  // Short latency so one-per-cycle streaming fits inside the DEPTH credits.
  localparam int unsigned LATENCY = 6;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TAG_W   = 4;
`ifdef CORDIC_COLLECT_BYPASS_EN
  localparam int ExpLat = LATENCY;
`else
  localparam int ExpLat = LATENCY + 1;
`endif

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               issue_valid = 1'b0;
  logic               issue_ready;
  logic [1:0]         issue_mode = 2'b00;
  logic [TAG_W-1:0]   issue_tag = '0;
  logic signed [31:0] pipe_x, pipe_y, pipe_angle;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [31:0] out_x, out_y, out_angle;
  logic [1:0]         out_mode;
  logic [TAG_W-1:0]   out_tag;
  logic [6:0]         inflight;

  always #5 clock = ~clock;

  cordic_result_collector #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_mode  (issue_mode),
    .issue_tag   (issue_tag),
    .pipe_x      (pipe_x),
    .pipe_y      (pipe_y),
    .pipe_angle  (pipe_angle),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_angle   (out_angle),
    .out_mode    (out_mode),
    .out_tag     (out_tag),
    .inflight    (inflight)
  );

  typedef struct packed {
    logic [31:0]      x;
    logic [31:0]      y;
    logic [31:0]      a;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
  } res_t;

  typedef struct packed {
    bit        act;
    bit [31:0] x;
    bit [31:0] y;
    bit [31:0] a;
  } core_t;

  res_t        sb[$];
  core_t       core_q [LATENCY];
  core_t       core_in;
  bit          ref_vld [LATENCY];
  int          ref_count, ref_inflight;
  int          errors, checks, cyc, n_acc, n_pop;
  bit          fix_en;
  logic [31:0] fix_x;
  logic [31:0] junk;

  // Core model: not reset, so ops issued before a reset still emerge afterwards.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int k = LATENCY - 1; k > 0; k--) core_q[k] <= core_q[k-1];
    core_q[0] <= core_in;
    junk <= $urandom;
  end

  assign pipe_x     = core_q[LATENCY-1].act ? core_q[LATENCY-1].x : junk;
  assign pipe_y     = core_q[LATENCY-1].act ? core_q[LATENCY-1].y : ~junk;
  assign pipe_angle = core_q[LATENCY-1].act ? core_q[LATENCY-1].a : (junk ^ 32'h5a5a_a5a5);

  // Reference model of credits/occupancy plus scoreboard push and pop.
  always @(negedge clock) begin
    bit   exp_ready, emerge, byp, exp_valid, acc, pop;
    res_t e, got;
    if (!reset_n) begin
      ref_count = 0;
      ref_inflight = 0;
      sb.delete();
      core_in = '0;
      for (int k = 0; k < LATENCY; k++) ref_vld[k] = 1'b0;
    end else begin
      exp_ready = (ref_count + ref_inflight) < DEPTH;
      checks++;
      if (issue_ready !== exp_ready) begin
        errors++;
        $display("FAIL issue_ready cyc=%0d got=%b exp=%b", cyc, issue_ready, exp_ready);
      end
      checks++;
      if (inflight !== 7'(ref_inflight)) begin
        errors++;
        $display("FAIL inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, ref_inflight);
      end
      emerge = ref_vld[LATENCY-1];
      byp = 1'b0;
`ifdef CORDIC_COLLECT_BYPASS_EN
      byp = (ref_count == 0) && emerge && (out_ready === 1'b1);
`endif
      exp_valid = (ref_count != 0) || byp;
      checks++;
      if (out_valid !== exp_valid) begin
        errors++;
        $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid);
      end
      acc = (issue_valid === 1'b1) && exp_ready;
      pop = exp_valid && (out_ready === 1'b1);
      if (pop) begin
        n_pop++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected cyc=%0d got_tag=%0d exp=none", cyc, out_tag);
        end else begin
          e = sb.pop_front();
          got = {out_x, out_y, out_angle, out_mode, out_tag};
          if (got !== e) begin
            errors++;
            $display("FAIL result_data cyc=%0d got=%h exp=%h", cyc, got, e);
          end
        end
      end
      core_in = '0;
      if (acc) begin
        n_acc++;
        e.x    = fix_en ? fix_x : $urandom;
        e.y    = $urandom;
        e.a    = $urandom;
        e.mode = issue_mode;
        e.tag  = issue_tag;
        sb.push_back(e);
        core_in.act = 1'b1;
        core_in.x   = e.x;
        core_in.y   = e.y;
        core_in.a   = e.a;
      end
      ref_count    = ref_count + int'(emerge && !byp) - int'(pop && !byp);
      ref_inflight = ref_inflight + int'(acc) - int'(emerge);
      for (int k = LATENCY - 1; k > 0; k--) ref_vld[k] = ref_vld[k-1];
      ref_vld[0] = acc;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    issue_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (inflight !== 7'd0) begin
      errors++; $display("FAIL reset_inflight got=%0d exp=0", inflight);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int t;
    int lat;
    bit seen;
    tick();
    tick();
    out_ready = 1'b1;
    issue_valid = 1'b1;
    issue_mode = 2'b10;
    issue_tag = TAG_W'(5);
    fix_en = 1'b1;
    fix_x = 32'h1234_5678;
    t = cyc;
    tick();
    issue_valid = 1'b0;
    fix_en = 1'b0;
    seen = 1'b0;
    lat = -1;
    for (int i = 0; i < LATENCY + 10 && !seen; i++) begin
      @(negedge clock);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        lat = cyc - t;
        checks++;
        if (out_tag !== TAG_W'(5) || out_x !== 32'sh1234_5678 || out_mode !== 2'b10) begin
          errors++;
          $display("FAIL single_fields got tag=%0d x=%h mode=%b exp tag=5 x=12345678 mode=10",
                   out_tag, out_x, out_mode);
        end
      end
    end
    checks++;
    if (!seen || lat != ExpLat) begin
      errors++; $display("FAIL single_latency got=%0d exp=%0d", lat, ExpLat);
    end
    tick();
    @(negedge clock);
    checks++;
    if (inflight !== 7'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got inflight=%0d valid=%b exp 0/0", inflight, out_valid);
    end
    tick();
  endtask

  task automatic test_credit();
    int acc;
    int t;
    acc = 0;
    out_ready = 1'b0;
    issue_valid = 1'b1;
    issue_mode = 2'b11;
    for (int i = 0; i < int'(LATENCY) + 20; i++) begin
      @(negedge clock);
      if (issue_ready === 1'b1) acc++;
      tick();
      issue_tag = issue_tag + 1'b1;
    end
    issue_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (acc != int'(DEPTH)) begin
      errors++; $display("FAIL credit_accepts got=%0d exp=%0d", acc, DEPTH);
    end
    checks++;
    if (issue_ready !== 1'b0 || inflight !== 7'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL credit_full got ready=%b inflight=%0d valid=%b exp 0/0/1",
               issue_ready, inflight, out_valid);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++; $display("FAIL credit_pop_same_cycle got=%b exp=0", issue_ready);
    end
    tick();
    out_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++; $display("FAIL credit_release got=%b exp=1", issue_ready);
    end
    // One more op fills the last credit; pop exactly in its emergence cycle.
    tick();
    issue_valid = 1'b1;
    t = cyc;
    tick();
    issue_valid = 1'b0;
    while (cyc < t + int'(LATENCY)) tick();
    out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL popwrite_before got ready=%b valid=%b exp 0/1", issue_ready, out_valid);
    end
    tick();
    out_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b1 || inflight !== 7'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL popwrite_after got ready=%b inflight=%0d valid=%b exp 1/0/1",
               issue_ready, inflight, out_valid);
    end
    tick();
    out_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL credit_drain got valid=%b pending=%0d exp 0/0", out_valid, sb.size());
    end
    tick();
  endtask

  task automatic test_stream();
    bit ready_drop;
    int first, last, gaps, got;
    ready_drop = 1'b0;
    first = -1;
    last = -1;
    gaps = 0;
    got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 + int'(LATENCY) + 10; i++) begin
      issue_valid = (i < 100);
      issue_tag = TAG_W'(i % 16);
      issue_mode = 2'(i % 4);
      @(negedge clock);
      if (issue_valid && issue_ready !== 1'b1) ready_drop = 1'b1;
      if (out_valid === 1'b1) begin
        if (first >= 0 && cyc != last + 1) gaps++;
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      tick();
    end
    issue_valid = 1'b0;
    checks++;
    if (ready_drop) begin
      errors++; $display("FAIL stream_ready got=dropped exp=held");
    end
    checks++;
    if (got != 100 || gaps != 0) begin
      errors++; $display("FAIL stream_results got=%0d gaps=%0d exp=100 gaps=0", got, gaps);
    end
  endtask

  task automatic test_random();
    int start;
    start = n_acc;
    for (int i = 0; i < 20000 && (n_acc - start) < 1000; i++) begin
      issue_valid = ($urandom_range(0, 9) < 8);
      out_ready = 1'($urandom_range(0, 1));
      issue_tag = TAG_W'($urandom_range(0, 15));
      issue_mode = 2'($urandom_range(0, 3));
      tick();
    end
    issue_valid = 1'b0;
    checks++;
    if ((n_acc - start) < 1000) begin
      errors++; $display("FAIL random_issue_count got=%0d exp>=1000", n_acc - start);
    end
    out_ready = 1'b1;
    repeat (LATENCY + DEPTH + 5) tick();
    @(negedge clock);
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0 || inflight !== 7'd0) begin
      errors++;
      $display("FAIL random_drain got pending=%0d valid=%b inflight=%0d exp 0/0/0",
               sb.size(), out_valid, inflight);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int stray;
    bit seen;
    out_ready = 1'b0;
    issue_valid = 1'b1;
    repeat (3) tick();
    issue_valid = 1'b0;
    repeat (LATENCY + 2) tick();
    issue_valid = 1'b1;
    repeat (5) tick();
    issue_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (inflight !== 7'd5 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrun_setup got inflight=%0d valid=%b exp 5/1", inflight, out_valid);
    end
    tick();
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || inflight !== 7'd0) begin
      errors++;
      $display("FAIL midrun_reset got valid=%b inflight=%0d exp 0/0", out_valid, inflight);
    end
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    stray = 0;
    for (int i = 0; i < 2 * int'(LATENCY) + 4; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) stray++;
      tick();
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL midrun_stray got=%0d exp=0", stray);
    end
    issue_valid = 1'b1;
    issue_tag = TAG_W'(9);
    tick();
    issue_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < int'(LATENCY) + 10 && !seen; i++) begin
      @(negedge clock);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL midrun_new_op got=none exp=result");
    end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    fix_en = 1'b0;
    fix_x = '0;
    core_in = '0;
    test_reset();
    test_single();
    test_credit();
    test_stream();
    test_random();
    test_reset_midrun();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_result_collector.md
# cordic_result_collector

Downstream companion to the pipelined CORDIC rotation core. Tracks every operation issued into the fixed-latency core with a tag/mode delay line, captures the core's x/y/angle outputs when the matching operation emerges, and buffers results in a FIFO behind a ready/valid output port. Credit-based issue control guarantees the non-stallable core never produces a result with nowhere to go.

## Interface
- LATENCY, 28: clock edges from issue acceptance to the matching result on pipe_*; legal range 1..63.
- DEPTH, 8: result FIFO entries; power of two, 2..64.
- TAG_W, 4: width of the caller's opaque tag.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  caller presents an operation this cycle; the core samples its inputs on the same edge.
- issue_ready  out  1  credit available; an issue is accepted when issue_valid && issue_ready.
- issue_mode  in  2  operation mode: 00 linear, 10 circular, 11 hyperbolic.
- issue_tag  in  TAG_W  returned unchanged with the result.
- pipe_x, pipe_y, pipe_angle  in  32 each  signed core outputs (rotated_x, rotated_y, final_angle).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts; a pop occurs when out_valid && out_ready.
- out_x, out_y, out_angle  out  32 each  signed result.
- out_mode  out  2, out_tag  out  TAG_W  metadata of the result.
- inflight  out  7  operations issued but not yet emerged.

## Operation
- Delay line: LATENCY registers of {valid, mode, tag}. Stage 0 loads {accept, issue_mode, issue_tag}. Stage k loads stage k-1 on every edge. No stall.
- Emergence: the last stage valid means pipe_* hold that operation's result in the current cycle. The collector writes {pipe_x, pipe_y, pipe_angle, mode, tag} into the FIFO on the closing edge.
- inflight counter: +1 on accept, -1 on emergence, unchanged when both occur.
- Credits: issue_ready = (fifo_count + inflight) < DEPTH. It is purely registered state, with no combinational path from issue_valid or out_ready. Invariant: fifo_count + inflight <= DEPTH, so a FIFO write never finds the FIFO full.
- FIFO: circular, first-in first-out. Read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. fifo_count = wptr - rptr.
- Simultaneous write and pop are permitted at any occupancy, including full. Count is unchanged in that case.
- Data is passed bit-exact. No scaling, no saturation, no sign manipulation.
- Mode 01 is forwarded unchanged.
- Outputs out_* other than out_valid are don't-care while out_valid=0. The bench must not check them.

## Timing
- Reset values: issue_ready=1, out_valid=0, inflight=0, out_x/out_y/out_angle=0, out_mode=0, out_tag=0. All delay-line valids are 0, and both FIFO pointers are 0.
- Reset mid-operation: all in-flight operations and buffered results are discarded. Results the core emits after reset release are ignored because the delay line is clear.
- Issue latency: an issue accepted in cycle t produces emergence in cycle t+LATENCY. Default build: out_valid in cycle t+LATENCY+1 when the FIFO is empty.
- Back-to-back issues at one per cycle are sustained while credits last. With out_ready held at 1, throughput is 1 result per cycle in steady state.
- Credit release timing: a pop in cycle c raises issue_ready no earlier than cycle c+1. An emergence does not release a credit; only a pop does.
- Output ordering: results emerge strictly in issue order.

## Configuration
- CORDIC_COLLECT_BYPASS_EN defined: if the FIFO is empty, an emergence is occurring, and out_ready=1, the result is presented combinationally on out_* with out_valid=1 in the emergence cycle. It is consumed without being written, so best-case latency is LATENCY cycles. When the FIFO is empty and out_ready=0, the result is written normally.
- Not defined: every result passes through the FIFO, giving LATENCY+1 cycle minimum latency. All outputs are registered or FIFO-driven.

## Test plan
- Single op: issue tag=5, mode=10 at cycle 3, out_ready=1, pipe_x driven with 0x12345678 at emergence. Required: out_valid in cycle 3+LATENCY+1 (bypass: 3+LATENCY), out_tag=5, out_x=0x12345678, inflight returns to 0.
- Credit exhaustion: out_ready=0, issue_valid held at 1. Required: exactly DEPTH=8 accepts, then issue_ready=0. After all emerge, fifo_count=8 and inflight=0. A single pop re-enables issue_ready the following cycle.
- Streaming: 100 consecutive issues with tags 0..15 cycling and out_ready=1. Required: 100 results in order with no gaps after the first, and issue_ready never deasserts.
- Random backpressure: out_ready toggled pseudo-randomly over 1000 issues. Required: no loss, no duplication, order preserved, and fifo_count + inflight <= 8 every cycle.
- Simultaneous pop and write at full (fifo_count=8 via pre-filled state): required count stays 8 and the head advances by one entry.
- Reset mid-run: assert reset_n=0 with 5 operations in flight and 3 buffered. Required: out_valid=0 and inflight=0 immediately, and no result appears after release until a new issue completes.
